full_adder: RTL and testbench
=============================

# full_adder

Single-bit full adder cell, the building block chained by the ripple carry adder. It provides a purely combinational sum/carry path so carries can ripple through WIDTH instances within one cycle. It also provides a one-cycle registered copy of the result with a valid flag for pipelined users. An optional carry-event counter supports debug.

## Interface
Parameters:
- CNT_WIDTH, default 16: width of the carry-event counter; legal range 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry in.
- sum  output  1  combinational: a ^ b ^ cin.
- cout  output  1  combinational: (a & b) | (a & cin) | (b & cin).
- in_valid  input  1  qualifies a/b/cin for the registered path.
- sum_q  output  1  registered sum.
- cout_q  output  1  registered cout.
- out_valid  output  1  sum_q/cout_q hold a result captured one cycle earlier.
- carry_cnt  output  CNT_WIDTH  saturating count of accepted carry-outs. Present only with FULL_ADDER_STATS_EN.

## Operation
- Combinational path:
  - sum and cout are pure functions of a, b, cin.
  - No dependence on clk, reset or in_valid.
  - No latch or X propagation when inputs are known.
  - Valid during reset.
- Arithmetic identity: {cout,sum} = a + b + cin as a 2-bit unsigned value, range 0..3.
- Registered path:
  - When in_valid = 1, sum_q/cout_q load the combinational sum/cout.
  - out_valid is a pure 1-cycle delay of in_valid.
  - When in_valid = 0, sum_q/cout_q hold their previous values.
- Carry counter (FULL_ADDER_STATS_EN):
  - Increments by 1 on each rising edge where in_valid = 1 and cout = 1.
  - Saturates at 2^CNT_WIDTH - 1; no wrap.
- No handshake backpressure; every valid input is accepted.
- No state machine.

## Timing
- sum/cout: zero-cycle latency, combinational only.
- sum_q/cout_q/out_valid: exactly 1 cycle after the in_valid cycle.
- Reset (reset = 0 at a rising edge): sum_q = 0, cout_q = 0, out_valid = 0, carry_cnt = 0.
- Reset overrides in_valid in the same cycle.
- Reset mid-stream: any in-flight result is discarded. The first out_valid after release follows the first in_valid sampled with reset = 1.
- Back-to-back in_valid: one result per cycle, out_valid stays high.
- Counter at maximum with a further carry: stays at maximum.

## Configuration
- Macro: FULL_ADDER_STATS_EN.
- Defined:
  - The carry_cnt port and counter logic exist.
  - CNT_WIDTH outside 1..32 is a static assertion failure at elaboration.
- Undefined:
  - No carry_cnt port and no counter flops.
  - All other behaviour is identical.
  - CNT_WIDTH is ignored.

## Test plan
- Truth table: apply all 8 {a,b,cin} combinations. Required {cout,sum}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11, in the same cycle.
- Registered latency:
  - Cycle 0: in_valid = 1, a = 1, b = 1, cin = 0. Cycle 1: sum_q = 0, cout_q = 1, out_valid = 1.
  - Cycle 1: in_valid = 0. Cycle 2: out_valid = 0, sum_q/cout_q unchanged.
- Reset:
  - Hold reset = 0 for 2 cycles with in_valid = 1 and a = b = cin = 1. All registered outputs and carry_cnt read 0; comb sum = 1, cout = 1 throughout.
  - Deassert reset: the next accepted input appears 1 cycle later.
- Ripple chain: 16 instances chained as the ripple carry adder, cin = 0.
  - a = b = 100: sum = 200, cout = 0.
  - a = b = 0x8000: sum = 0, cout = 1.
  - a = b = 0xFFFF: sum = 0xFFFE, cout = 1.
- Counter saturation (macro defined, CNT_WIDTH = 2): 5 accepted cycles with cout = 1. carry_cnt reads 1, 2, 3, 3, 3.
- Counter gating: 4 cycles with cout = 1 and in_valid = 0. carry_cnt unchanged.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
// The combinational sum/cout path lets carries ripple through chained cells
// within one cycle. A registered copy of the result with a valid flag serves
// pipelined users.
// Optional macro FULL_ADDER_STATS_EN adds carry_cnt, a saturating count of
// accepted carry-outs that is CNT_WIDTH bits wide (1..32).
module full_adder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    input  logic in_valid,
    output logic sum_q,
    output logic cout_q,
    output logic out_valid
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] carry_cnt
`endif
);

    // Pure combinational sum/carry, independent of clock, reset and in_valid
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

    // Registered result: capture on in_valid, hold otherwise; valid is a 1-cycle delay
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q     <= 1'b0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end

`ifdef FULL_ADDER_STATS_EN
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
        $error("full_adder: CNT_WIDTH must be in 1..32");
    end

    // Saturating count of accepted cycles that produce a carry-out
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_cnt <= '0;
        end else if (in_valid && cout && (carry_cnt != '1)) begin
            carry_cnt <= carry_cnt + 1'b1;
        end
    end
`else
    // CNT_WIDTH has no effect without the counter; this block is always empty
    if (CNT_WIDTH < 0) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder: truth table, registered latency, reset behaviour,
// randomized traffic against a behavioural model, a 16-bit ripple chain and,
// when FULL_ADDER_STATS_EN is defined, counter saturation and gating.
module tb_full_adder;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk;
    logic reset;
    logic a, b, cin, in_valid;
    logic sum, cout, sum_q, cout_q, out_valid;
`ifdef FULL_ADDER_STATS_EN
    logic [TB_CNT_W-1:0] carry_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the registered state
    logic m_sum_q, m_cout_q, m_valid;
    int   m_cnt;

    full_adder #(.CNT_WIDTH(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .in_valid  (in_valid),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .out_valid (out_valid)
`ifdef FULL_ADDER_STATS_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    // 16-cell ripple chain built from the same cell
    logic [15:0] ra, rb, rs;
    logic [16:0] rc;
    logic [15:0] r_sq, r_cq, r_ov;
`ifdef FULL_ADDER_STATS_EN
    logic [TB_CNT_W-1:0] r_cnt [16];
`endif
    assign rc[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_chain
        full_adder #(.CNT_WIDTH(TB_CNT_W)) u_fa (
            .clk       (clk),
            .reset     (reset),
            .a         (ra[i]),
            .b         (rb[i]),
            .cin       (rc[i]),
            .sum       (rs[i]),
            .cout      (rc[i+1]),
            .in_valid  (1'b0),
            .sum_q     (r_sq[i]),
            .cout_q    (r_cq[i]),
            .out_valid (r_ov[i])
`ifdef FULL_ADDER_STATS_EN
            ,
            .carry_cnt (r_cnt[i])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        int s;
        logic n_sq, n_cq, n_v;
        int n_cnt;
        s     = int'(a) + int'(b) + int'(cin);
        n_sq  = m_sum_q;
        n_cq  = m_cout_q;
        n_cnt = m_cnt;
        if (!reset) begin
            n_sq = 1'b0; n_cq = 1'b0; n_v = 1'b0; n_cnt = 0;
        end else begin
            n_v = in_valid;
            if (in_valid) begin
                n_sq = (s % 2) == 1;
                n_cq = s >= 2;
                if (s >= 2 && n_cnt < CNT_MAX) n_cnt = n_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        m_sum_q  = n_sq;
        m_cout_q = n_cq;
        m_valid  = n_v;
        m_cnt    = n_cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        ra = '0; rb = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cout, sum} !== 2'b11) begin
                failures++;
                $display("FAIL reset_comb: got %b%b want 11", cout, sum);
            end
            checks++;
            if ({sum_q, cout_q, out_valid} !== 3'b000) begin
                failures++;
                $display("FAIL reset_regs: got sum_q=%b cout_q=%b out_valid=%b want 000",
                         sum_q, cout_q, out_valid);
            end
`ifdef FULL_ADDER_STATS_EN
            checks++;
            if (carry_cnt !== '0) begin
                failures++;
                $display("FAIL reset_cnt: got %0d want 0", carry_cnt);
            end
`endif
        end
        // First accepted input after release appears one cycle later
        reset = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({sum_q, cout_q, out_valid} !== 3'b101) begin
            failures++;
            $display("FAIL reset_release: got sum_q=%b cout_q=%b out_valid=%b want 101",
                     sum_q, cout_q, out_valid);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] tt [8];
        logic [2:0] v;
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            checks++;
            if ({cout, sum} !== tt[i]) begin
                failures++;
                $display("FAIL truth_table abc=%b: got %b%b want %b", v, cout, sum, tt[i]);
            end
        end
        tick();
    endtask

    task automatic test_latency();
        logic hs, hc;
        in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
        tick();
        checks++;
        if ({sum_q, cout_q, out_valid} !== 3'b011) begin
            failures++;
            $display("FAIL latency_cycle1: got sum_q=%b cout_q=%b out_valid=%b want 011",
                     sum_q, cout_q, out_valid);
        end
        hs = sum_q; hc = cout_q;
        in_valid = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b1;
        tick();
        checks++;
        if ({sum_q, cout_q, out_valid} !== 3'b010) begin
            failures++;
            $display("FAIL latency_hold: got sum_q=%b cout_q=%b out_valid=%b want 010",
                     sum_q, cout_q, out_valid);
        end
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 200; i++) begin
            a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
            in_valid = 1'($urandom);
            #1;
            s = int'(a) + int'(b) + int'(cin);
            checks++;
            if ({cout, sum} !== 2'(s)) begin
                failures++;
                $display("FAIL random_comb: got %b%b want %0d", cout, sum, s);
            end
            tick();
            checks++;
            if (sum_q !== m_sum_q || cout_q !== m_cout_q || out_valid !== m_valid) begin
                failures++;
                $display("FAIL random_regs: got %b%b%b want %b%b%b",
                         sum_q, cout_q, out_valid, m_sum_q, m_cout_q, m_valid);
            end
`ifdef FULL_ADDER_STATS_EN
            checks++;
            if (int'(carry_cnt) !== m_cnt) begin
                failures++;
                $display("FAIL random_cnt: got %0d want %0d", carry_cnt, m_cnt);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || sum_q !== m_sum_q || cout_q !== m_cout_q) begin
                failures++;
                $display("FAIL back_to_back %0d: got %b%b%b want %b%b1",
                         i, sum_q, cout_q, out_valid, m_sum_q, m_cout_q);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1; in_valid = 1'b1; a = 1'b0; b = 1'b1; cin = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        tick();
        checks++;
        if ({sum_q, cout_q, out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_clear: got %b%b%b want 000", sum_q, cout_q, out_valid);
        end
        reset = 1'b1; in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_discard: got out_valid=%b want 0", out_valid);
        end
        in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({sum_q, cout_q, out_valid} !== 3'b111) begin
            failures++;
            $display("FAIL midreset_first: got %b%b%b want 111", sum_q, cout_q, out_valid);
        end
    endtask

    task automatic test_ripple();
        logic [15:0] va [3];
        logic [16:0] want [3];
        logic [16:0] exp17;
        va   = '{16'd100, 16'h8000, 16'hFFFF};
        want = '{17'd200, 17'h10000, 17'h1FFFE};
        for (int i = 0; i < 3; i++) begin
            ra = va[i]; rb = va[i];
            #1;
            checks++;
            if ({rc[16], rs} !== want[i]) begin
                failures++;
                $display("FAIL ripple %h: got %h want %h", va[i], {rc[16], rs}, want[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            #1;
            exp17 = 17'(int'(ra) + int'(rb));
            checks++;
            if ({rc[16], rs} !== exp17) begin
                failures++;
                $display("FAIL ripple_rand %h+%h: got %h want %h", ra, rb, {rc[16], rs}, exp17);
            end
        end
    endtask

`ifdef FULL_ADDER_STATS_EN
    task automatic test_counter();
        int want [5];
        want = '{1, 2, 3, 3, 3};
        reset = 1'b0; in_valid = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (int'(carry_cnt) !== want[i]) begin
                failures++;
                $display("FAIL cnt_sat %0d: got %0d want %0d", i, carry_cnt, want[i]);
            end
        end
        // Drop back below saturation to observe gating on a live counter
        reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (int'(carry_cnt) !== 1) begin
                failures++;
                $display("FAIL cnt_gate %0d: got %0d want 1", i, carry_cnt);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        ra = '0; rb = '0;
        m_sum_q = 1'b0; m_cout_q = 1'b0; m_valid = 1'b0; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_truth_table();
        test_latency();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        test_ripple();
`ifdef FULL_ADDER_STATS_EN
        test_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
